grad_mux_valve_seq: RTL
=======================

Name: grad_mux_valve_seq

Overview:
- Clocked sequencer that drives the four control-pressure lines of the 4-outlet gradient MUX feeding the long cell-trap bank.
- Routes the gradient-generator output to one trap channel, or scans all four in turn, with break-before-make valve timing and a programmable dwell per channel.
- Sits between the host command interface and the off-chip solenoid drivers that pressurise cpb1_1/cpb1_2/cpb2_1/cpb2_2.

Parameters:
- SETTLE_CYC, 16, cycles that all valves are held closed before any path opens.
- DWELL_W, 16, width of the dwell counter and of cmd_dwell.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer accepts a command
- cmd_chan  in  2  target channel (single) or start channel (scan)
- cmd_scan  in  1  1 = visit 4 channels, 0 = single channel
- cmd_dwell  in  DWELL_W  open time per channel in cycles; 0 is treated as 1
- abort  in  1  terminate current operation
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort completion
- cur_chan  out  2  channel currently open
- chan_open  out  1  a flow path is open (cur_chan valid)
- vb0_t  out  1  bit-0 true valve (cpb1_1); 1 = pressurised/closed
- vb0_f  out  1  bit-0 complement valve (cpb1_2)
- vb1_t  out  1  bit-1 true valve (cpb2_1)
- vb1_f  out  1  bit-1 complement valve (cpb2_2)

Behaviour:
- Reset (synchronous, active-high): all four valve outputs = 1 (every path blocked). busy = 0, done = 0, aborted = 0, chan_open = 0, cur_chan = 0, state = IDLE. cmd_ready = 0 while rst is high.
- Valve encoding for open channel c: vbk_t = ~c[k], vbk_f = c[k]. In every state except OPEN, all four valve outputs = 1.
- Valve outputs are registered, with no combinational path from any input.
- cmd_ready = 1 only in IDLE. A command is accepted on cmd_valid & cmd_ready. On acceptance, chan, scan, dwell and a visit count (4 for scan, 1 for single) are latched.
- States:
  - IDLE: valves closed. On accept -> CLOSE, busy = 1 from the next cycle.
  - CLOSE: settle counter runs SETTLE_CYC cycles with all valves closed, then -> OPEN.
  - OPEN: selected pattern is driven and chan_open = 1. Dwell counter runs max(dwell,1) cycles. At expiry the visit count is decremented. If the count is nonzero, chan = chan + 1 mod 4 (3 wraps to 0) and -> CLOSE. Otherwise -> FINISH.
  - FINISH: all valves closed, done = 1 for one cycle, -> IDLE. busy drops in the same cycle that IDLE is entered.
  - ABORT_CLOSE: all valves closed for SETTLE_CYC cycles, then aborted = 1 for one cycle, -> IDLE. done is not pulsed.
- Timing: with accept at cycle 0, the first OPEN cycle is cycle 1+SETTLE_CYC. Single-channel done is at cycle 1+SETTLE_CYC+max(dwell,1).
- Break-before-make: between any two distinct open patterns there are at least SETTLE_CYC consecutive all-closed cycles. Two valves of the same bit are never both 0.
- abort:
  - Sampled in CLOSE or OPEN: -> ABORT_CLOSE next cycle, valves close on that cycle, settle counter restarts.
  - Ignored in IDLE, FINISH and ABORT_CLOSE.
  - abort and dwell expiry in the same cycle: abort wins.
- cmd_valid while busy: not accepted. The sequencer holds no skid buffer.
- rst mid-operation: immediate return to the reset values on the next edge. Valves close and no done or aborted pulse is produced.
- Counters saturate-free. Both counters are wide enough for SETTLE_CYC and 2^DWELL_W-1.

Decomposition:
- Shared package grad_mux_pkg holds:
  - state enum (IDLE, CLOSE, OPEN, FINISH, ABORT_CLOSE)
  - CHAN_W = 2, NUM_CHAN = 4
  - VALVE_CLOSED = 1
  - a function chan_to_valves(chan) returning the 4-bit {vb1_f, vb1_t, vb0_f, vb0_t} pattern.
- One natural sub-module: valve_timer, a loadable down-counter with an expire flag, instantiated twice (settle and dwell).

Test Plan:
- Reset then idle: valves = 4'b1111, cmd_ready = 1, busy = 0 for 20 cycles.
- Single, SETTLE_CYC=16, chan=2, dwell=5, accept at t0:
  - t0+1..t0+16: valves all 1.
  - t0+17..t0+21: vb1_t=0, vb1_f=1, vb0_t=1, vb0_f=0, cur_chan=2, chan_open=1.
  - done pulses at t0+22.
- Scan from chan=3, dwell=3: open sequence 3,0,1,2, each preceded by exactly 16 all-closed cycles. Single done after the 4th dwell; total busy = 4*(16+3)+1 cycles.
- dwell=0, chan=1: exactly one open cycle, then done.
- abort on the 2nd open cycle of a scan: valves all 1 on the next cycle, aborted pulses 16 cycles later, done never asserted, cmd_ready returns.
- rst asserted during OPEN: valves 4'b1111 on the next cycle, busy=0, no pulses. cmd_valid held during busy is not accepted until IDLE.

Source files
------------

// File: rtl/grad_mux_pkg.sv
// Shared types and helpers for the gradient MUX valve sequencer.
package grad_mux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLOSE,
    OPEN,
    FINISH,
    ABORT_CLOSE
  } state_t;

  localparam int   CHAN_W       = 2;
  localparam int   NUM_CHAN     = 4;
  localparam logic VALVE_CLOSED = 1'b1;

  // Returns {vb1_f, vb1_t, vb0_f, vb0_t}; a 0 vents that valve so the path flows.
  function automatic logic [3:0] chan_to_valves(input logic [CHAN_W-1:0] chan);
    return {chan[1], ~chan[1], chan[0], ~chan[0]};
  endfunction

endpackage

// File: rtl/grad_mux_valve_seq_valve_timer.sv
// Loadable down-counter; expire is high on the last cycle of a loaded interval.
module valve_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/grad_mux_valve_seq.sv
// Break-before-make sequencer for the 4-outlet gradient MUX control lines.
module grad_mux_valve_seq
  import grad_mux_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int DWELL_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CHAN_W-1:0]  cmd_chan,
  input  logic               cmd_scan,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CHAN_W-1:0]  cur_chan,
  output logic               chan_open,
  output logic               vb0_t,
  output logic               vb0_f,
  output logic               vb1_t,
  output logic               vb1_f
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  state_t              state, state_n;
  logic [CHAN_W-1:0]   chan, chan_n;
  logic [DWELL_W-1:0]  dwell;
  logic [2:0]          visits;
  logic [3:0]          valves;
  logic                aborted_q;
  logic                accept;
  logic                settle_load, settle_exp;
  logic                dwell_load, dwell_exp;
  logic [DWELL_W-1:0]  dwell_eff;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    chan_n  = chan;
    case (state)
      IDLE:        if (accept) state_n = CLOSE;
      CLOSE:       if (abort) state_n = ABORT_CLOSE;
                   else if (settle_exp) state_n = OPEN;
      // abort is checked first so it beats a coincident dwell expiry
      OPEN:        if (abort) state_n = ABORT_CLOSE;
                   else if (dwell_exp) begin
                     if (visits == 3'd1) state_n = FINISH;
                     else begin
                       chan_n  = chan + 1'b1;
                       state_n = CLOSE;
                     end
                   end
      FINISH:      state_n = IDLE;
      ABORT_CLOSE: if (settle_exp) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
    if (accept) chan_n = cmd_chan;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan      <= '0;
      dwell     <= '0;
      visits    <= '0;
      valves    <= {4{VALVE_CLOSED}};
      aborted_q <= 1'b0;
    end else begin
      chan <= chan_n;
      if (accept) begin
        dwell  <= cmd_dwell;
        visits <= cmd_scan ? 3'd4 : 3'd1;
      end else if (state == OPEN && dwell_exp && !abort) begin
        visits <= visits - 1'b1;
      end
      // Valves are registered from the next state so they change with the state itself.
      valves    <= (state_n == OPEN) ? chan_to_valves(chan_n) : {4{VALVE_CLOSED}};
      aborted_q <= (state == ABORT_CLOSE) && settle_exp;
    end
  end

  assign settle_load = (state_n != state) && (state_n == CLOSE || state_n == ABORT_CLOSE);
  assign dwell_load  = (state_n == OPEN) && (state != OPEN);
  assign dwell_eff   = (dwell == '0) ? DWELL_W'(1) : dwell;

  valve_timer #(.W(SW)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load),
    .load_val (SW'(SETTLE_CYC)),
    .expire   (settle_exp)
  );

  valve_timer #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (dwell_load),
    .load_val (dwell_eff),
    .expire   (dwell_exp)
  );

  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign aborted   = aborted_q;
  assign cur_chan  = chan;
  assign chan_open = (state == OPEN);
  assign vb0_t     = valves[0];
  assign vb0_f     = valves[1];
  assign vb1_t     = valves[2];
  assign vb1_f     = valves[3];

endmodule
